// File: rtl/arrayed_ser_pkg.sv
// Shared types and default sizing for the arrayed symbol serializer.
// Optional parity symbol support is enabled with macro ARRAYED_SER_PARITY_EN.
package arrayed_ser_pkg;

  localparam int DEF_NUM_ENTRIES = 4;
  localparam int DEF_ENTRY_W     = 2;

`ifdef ARRAYED_SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
`endif

  // Symbol index width; a single-entry word still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arrayed_ser_shreg.sv
// Load/shift register for the serializer: entry 0 sits in the MSBs and is
// presented as the head symbol; each advance shifts the next entry up.
module arrayed_ser_shreg
  import arrayed_ser_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int ENTRY_W     = DEF_ENTRY_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic                           advance,
  input  logic [NUM_ENTRIES*ENTRY_W-1:0] load_data,
  output logic [ENTRY_W-1:0]             head
);

  localparam int WORD_W = NUM_ENTRIES * ENTRY_W;

  logic [WORD_W-1:0] data_q;

  // Zeros shift in from the bottom, so the head reads zero once a frame drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (advance) begin
      data_q <= data_q << ENTRY_W;
    end
  end

  assign head = data_q[WORD_W-1 -: ENTRY_W];

endmodule

// File: rtl/arrayed_sig_serializer.sv
// Serializes a packed word of NUM_ENTRIES entries into ENTRY_W-bit symbols,
// e0 first, with valid/ready handshakes on both sides and a frame counter.
// Macro ARRAYED_SER_PARITY_EN appends a parity symbol to every frame.
module arrayed_sig_serializer
  import arrayed_ser_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int ENTRY_W     = DEF_ENTRY_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_ENTRIES*ENTRY_W-1:0] in_word,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [ENTRY_W-1:0]             sym_out,
  output logic                           sym_valid,
  input  logic                           sym_ready,
  output logic                           sym_last,
  output logic [7:0]                     frame_cnt
);

  localparam int IDX_W = idx_width(NUM_ENTRIES);

  ser_state_t       state_q;
  ser_state_t       state_d;
  logic [IDX_W-1:0] idx_q;
  logic             load;
  logic             advance;
  logic             last_data;
  logic             frame_done;
  logic [ENTRY_W-1:0] head;

`ifdef ARRAYED_SER_PARITY_EN
  logic parity_q;
`endif

  arrayed_ser_shreg #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ENTRY_W     (ENTRY_W)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (advance),
    .load_data (in_word),
    .head      (head)
  );

  assign last_data  = (idx_q == IDX_W'(NUM_ENTRIES - 1));
  assign frame_done = sym_valid && sym_ready && sym_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        idx_q <= '0;
      end else if (advance) begin
        idx_q <= idx_q + 1'b1;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

`ifdef ARRAYED_SER_PARITY_EN
  // Parity is taken from the whole word at capture, before any shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^in_word;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sym_valid = 1'b1;
`ifndef ARRAYED_SER_PARITY_EN
        sym_last  = last_data;
`endif
        if (sym_ready) begin
          advance = 1'b1;
          if (last_data) begin
`ifdef ARRAYED_SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef ARRAYED_SER_PARITY_EN
      PARITY: begin
        sym_valid = 1'b1;
        sym_last  = 1'b1;
        if (sym_ready) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sym_out = head;
`ifdef ARRAYED_SER_PARITY_EN
    if (state_q == PARITY) begin
      sym_out = ENTRY_W'(parity_q);
    end
`endif
  end

endmodule

// File: tb/tb_arrayed_sig_serializer.sv
// Directed self-checking bench for arrayed_sig_serializer (default parameters).
// Expectations follow the ARRAYED_SER_PARITY_EN setting of the build.
module tb_arrayed_sig_serializer;

  localparam int NE = 4;
  localparam int EW = 2;
`ifdef ARRAYED_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_word;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] sym_out;
  logic          sym_valid;
  logic          sym_ready;
  logic          sym_last;
  logic [7:0]    frame_cnt;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  arrayed_sig_serializer #(
    .NUM_ENTRIES (NE),
    .ENTRY_W     (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_last  (sym_last),
    .frame_cnt (frame_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] w, input logic sr);
    rst       = r;
    in_valid  = v;
    in_word   = w;
    sym_ready = sr;
  endtask

  task automatic expectSym(input string tag, input logic [EW-1:0] sym, input logic last);
    checkOutput({tag, ".valid"}, 32'(sym_valid), 32'd1);
    checkOutput({tag, ".sym"}, 32'(sym_out), 32'(sym));
    checkOutput({tag, ".last"}, 32'(sym_last), 32'(last));
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic expectIdle(input string tag, input logic [7:0] cnt);
    checkOutput({tag, ".valid"}, 32'(sym_valid), 32'd0);
    checkOutput({tag, ".last"}, 32'(sym_last), 32'd0);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(cnt));
  endtask

  // Walks a full frame with sym_ready high, starting just after the capture edge.
  task automatic expectFrame(input string tag, input logic [7:0] word);
    logic [7:0] sh;
    for (int i = 0; i < NE; i++) begin
      sh = word << (EW * i);
      expectSym($sformatf("%s.e%0d", tag, i), sh[7:6], !PAR && (i == NE - 1));
      tick();
    end
`ifdef ARRAYED_SER_PARITY_EN
    expectSym({tag, ".par"}, {1'b0, ^word}, 1'b1);
    tick();
`endif
  endtask

  task automatic runFrame(input logic [7:0] word);
    applyStimulus(1'b0, 1'b1, word, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (NE + int'(PAR)) tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with the interface quiet
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("rst.in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst.sym_valid", 32'(sym_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    expectIdle("reset", 8'd0);
    checkOutput("reset.sym_out", 32'(sym_out), 32'd0);

    // Basic frame: 10_01_11_00 -> 2,1,3,0
    applyStimulus(1'b0, 1'b1, 8'b10_01_11_00, 1'b1);
    tick();
    in_valid = 1'b0;
    expectSym("t1.s0", 2'd2, 1'b0);
    tick();
    expectSym("t1.s1", 2'd1, 1'b0);
    tick();
    expectSym("t1.s2", 2'd3, 1'b0);
    tick();
    expectSym("t1.s3", 2'd0, !PAR);
    tick();
`ifdef ARRAYED_SER_PARITY_EN
    // 10011100 has four ones, so the parity symbol is 0
    expectSym("t1.par", 2'd0, 1'b1);
    tick();
`endif
    expectIdle("t1.done", 8'd1);

    // Backpressure on the second symbol for three cycles
    applyStimulus(1'b0, 1'b1, 8'b10_01_11_00, 1'b1);
    tick();
    in_valid = 1'b0;
    expectSym("t2.s0", 2'd2, 1'b0);
    tick();
    expectSym("t2.s1", 2'd1, 1'b0);
    sym_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expectSym($sformatf("t2.hold%0d", k), 2'd1, 1'b0);
    end
    sym_ready = 1'b1;
    tick();
    expectSym("t2.s2", 2'd3, 1'b0);
    tick();
    expectSym("t2.s3", 2'd0, !PAR);
    tick();
`ifdef ARRAYED_SER_PARITY_EN
    expectSym("t2.par", 2'd0, 1'b1);
    tick();
`endif
    expectIdle("t2.done", 8'd2);

    // in_valid held high: word changes mid-frame are ignored, one idle gap
    applyStimulus(1'b0, 1'b1, 8'b11_00_01_10, 1'b1);
    tick();
    in_word = 8'b00_01_10_11;
    expectFrame("t3a", 8'b11_00_01_10);
    expectIdle("t3.gap", 8'd3);
    tick();
    in_valid = 1'b0;
    expectFrame("t3b", 8'b00_01_10_11);
    expectIdle("t3.done", 8'd4);

    // Reset during the third symbol, with in_valid still high
    applyStimulus(1'b0, 1'b1, 8'b10_01_11_00, 1'b1);
    tick();
    expectSym("t4.s0", 2'd2, 1'b0);
    tick();
    expectSym("t4.s1", 2'd1, 1'b0);
    tick();
    expectSym("t4.s2", 2'd3, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("t4.rst.valid", 32'(sym_valid), 32'd0);
    checkOutput("t4.rst.last", 32'(sym_last), 32'd0);
    checkOutput("t4.rst.frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("t4.rst.in_ready", 32'(in_ready), 32'd0);
    checkOutput("t4.rst.sym_out", 32'(sym_out), 32'd0);
    tick();
    checkOutput("t4.rst2.valid", 32'(sym_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'b01_10_00_11, 1'b1);
    #1;
    checkOutput("t4.post.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    expectFrame("t4", 8'b01_10_00_11);
    expectIdle("t4.done", 8'd1);

    // Frame counter wrap: 1 + 254 = 255, one more frame wraps to 0
    for (int f = 0; f < 254; f++) begin
      runFrame(8'(f));
    end
    checkOutput("wrap.255", 32'(frame_cnt), 32'd255);
    applyStimulus(1'b0, 1'b1, 8'b11_10_01_00, 1'b1);
    tick();
    in_valid = 1'b0;
    expectFrame("wrap", 8'b11_10_01_00);
    expectIdle("wrap.0", 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
